// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding control slice.
//   - FWD_* : select codes for the EX-stage operand muxes
//   - slot_t : shadow record of one pipeline slot's destination tag
//   - slots_t: EX/MEM/WB shadow slots bundled for observation
package pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_WB      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      wr;
    logic                      ld;
  } slot_t;

  typedef struct packed {
    slot_t ex;
    slot_t mem;
    slot_t wb;
  } slots_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with freeze.
//   clk, reset_n : clock, synchronous active-low reset
//   inc_i        : count one event this edge
//   hold_i       : freeze; count does not change
//   count_o      : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!hold_i && inc_i && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for a five-stage pipeline.
// Tracks destination-register tags of the EX, MEM and WB slots, so no
// datapath values are needed.
//   mem_wait                 : global freeze, holds all internal state
//   id_*                     : decoded fields of the instruction in ID
//   ex_branch_taken          : EX instruction redirects the PC
//   fwd_a_sel / fwd_b_sel    : registered operand-mux selects for EX
//   stall_if_id, flush_if_id : combinational IF/ID controls
//   stall_count, flush_count : saturating event counters
//   dbg_slots                : shadow slots, for observation only
// Handshake: none; every input is sampled each rising edge unless
// mem_wait = 1, in which case only the combinational outputs follow inputs.
module hazard_forward_ctrl
  import pipe_pkg::*;
#(
  // Must match REG_ADDR_W_DEF, which sizes the shadow slot record.
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_wait,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count,
  output slots_t                dbg_slots
);

  slot_t      ex_q, mem_q, wb_q;
  slot_t      ex_d;
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  // A slot produces r when it is live, writes, and r is not x0.
  function automatic logic slot_writes(input logic                  valid,
                                       input logic                  wr,
                                       input logic [REG_ADDR_W-1:0] rd,
                                       input logic [REG_ADDR_W-1:0] r);
    return valid && wr && (rd != '0) && (rd == r);
  endfunction

  logic ex_wr_a, ex_wr_b, mem_wr_a, mem_wr_b;
  logic hz, flush, stall;

  always_comb begin
    ex_wr_a  = slot_writes(ex_q.valid,  ex_q.wr,  ex_q.rd,  id_rs1);
    ex_wr_b  = slot_writes(ex_q.valid,  ex_q.wr,  ex_q.rd,  id_rs2);
    mem_wr_a = slot_writes(mem_q.valid, mem_q.wr, mem_q.rd, id_rs1);
    mem_wr_b = slot_writes(mem_q.valid, mem_q.wr, mem_q.rd, id_rs2);

    // Load result is not available until MEM, so a dependent in ID waits.
    hz    = id_valid && ex_q.ld &&
            ((id_use_rs1 && ex_wr_a) || (id_use_rs2 && ex_wr_b));
    flush = ex_branch_taken && ex_q.valid;
    // A squashed ID instruction needs no stall.
    stall = hz && !flush;
  end

  always_comb begin
    ex_d.valid = id_valid && !flush && !stall;
    ex_d.rd    = id_rd;
    ex_d.wr    = id_reg_write;
    ex_d.ld    = id_mem_read;

    // Nearest producer wins; WB is covered by write-before-read.
    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;
    if (ex_d.valid && id_use_rs1) begin
      if (ex_wr_a)       fwd_a_d = FWD_MEM;
      else if (mem_wr_a) fwd_a_d = FWD_WB;
    end
    if (ex_d.valid && id_use_rs2) begin
      if (ex_wr_b)       fwd_b_d = FWD_MEM;
      else if (mem_wr_b) fwd_b_d = FWD_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else if (!mem_wait) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (stall),
    .hold_i  (mem_wait),
    .count_o (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (flush),
    .hold_i  (mem_wait),
    .count_o (flush_count)
  );

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_if_id = stall;
  assign flush_if_id = flush;
  assign dbg_slots   = '{ex: ex_q, mem: mem_q, wb: wb_q};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;
  import pipe_pkg::*;

  localparam int RW    = 5;
  localparam int CNT_W = 2;   // small so saturation is reachable

  logic             clk;
  logic             reset_n;
  logic             mem_wait;
  logic             id_valid;
  logic [RW-1:0]    id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic             ex_branch_taken;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall_if_id, flush_if_id;
  logic [CNT_W-1:0] stall_count, flush_count;
  slots_t           dbg_slots;

  int n_checks = 0;
  int n_errors = 0;

  hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_wait        (mem_wait),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .dbg_slots       (dbg_slots)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_id(input logic v, input logic [RW-1:0] rs1, input logic u1,
                        input logic [RW-1:0] rs2, input logic u2,
                        input logic [RW-1:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld;
    #1;
  endtask

  task automatic id_idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_wait = 1'b0; ex_branch_taken = 1'b0;
    id_idle();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL reset_fwd_a: got %0d expected 0", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL reset_fwd_b: got %0d expected 0", fwd_b_sel); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b expected 0", stall_if_id); end
    n_checks++; if (flush_if_id !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %0b expected 0", flush_if_id); end
    n_checks++; if (stall_count !== '0) begin n_errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_count); end
    n_checks++; if (flush_count !== '0) begin n_errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_count); end
    n_checks++; if (dbg_slots !== slots_t'(0)) begin n_errors++; $display("FAIL reset_slots: got %h expected 0", dbg_slots); end
  endtask

  // add x5,x1,x2 ; sub x6,x5,x1
  task automatic test_alu_chain();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL alu_first_a: got %0d expected 0", fwd_a_sel); end
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    n_checks++; if (stall_if_id !== 1'b0) begin n_errors++; $display("FAIL alu_stall: got %0b expected 0", stall_if_id); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'd2) begin n_errors++; $display("FAIL alu_fwd_a: got %0d expected 2", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL alu_fwd_b: got %0d expected 0", fwd_b_sel); end
    id_idle();
  endtask

  // add x7 ; addi x0,x0,0 ; or x8,x7,x7
  task automatic test_distance2();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    n_checks++; if (fwd_a_sel !== 2'd1) begin n_errors++; $display("FAIL dist2_fwd_a: got %0d expected 1", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd1) begin n_errors++; $display("FAIL dist2_fwd_b: got %0d expected 1", fwd_b_sel); end
    id_idle();
  endtask

  // lw x9,0(x3) ; add x10,x9,x2
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    n_checks++; if (stall_if_id !== 1'b1) begin n_errors++; $display("FAIL lu_stall_on: got %0b expected 1", stall_if_id); end
    tick();
    n_checks++; if (dbg_slots.ex.valid !== 1'b0) begin n_errors++; $display("FAIL lu_bubble: got %0b expected 0", dbg_slots.ex.valid); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_errors++; $display("FAIL lu_stall_off: got %0b expected 0", stall_if_id); end
    n_checks++; if (stall_count !== 2'd1) begin n_errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_count); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'd1) begin n_errors++; $display("FAIL lu_fwd_a: got %0d expected 1", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL lu_fwd_b: got %0d expected 0", fwd_b_sel); end
    n_checks++; if (stall_count !== 2'd1) begin n_errors++; $display("FAIL lu_stall_cnt2: got %0d expected 1", stall_count); end
    id_idle();
  endtask

  // addi x0,x1,5 ; add x3,x0,x0 ; lw x0,0(x1) ; add x4,x0,x0
  task automatic test_zero_reg();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL zero_fwd_a: got %0d expected 0", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL zero_fwd_b: got %0d expected 0", fwd_b_sel); end
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    n_checks++; if (stall_if_id !== 1'b0) begin n_errors++; $display("FAIL zero_ld_stall: got %0b expected 0", stall_if_id); end
    tick();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL zero_ld_fwd_a: got %0d expected 0", fwd_a_sel); end
    id_idle();
  endtask

  // lw x9 in EX, branch taken, add x10,x9,x2 in ID
  task automatic test_flush_vs_stall();
    do_reset();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    n_checks++; if (flush_if_id !== 1'b1) begin n_errors++; $display("FAIL fvs_flush: got %0b expected 1", flush_if_id); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_errors++; $display("FAIL fvs_stall: got %0b expected 0", stall_if_id); end
    tick();
    ex_branch_taken = 1'b0;
    n_checks++; if (flush_count !== 2'd1) begin n_errors++; $display("FAIL fvs_flush_cnt: got %0d expected 1", flush_count); end
    n_checks++; if (stall_count !== 2'd0) begin n_errors++; $display("FAIL fvs_stall_cnt: got %0d expected 0", stall_count); end
    n_checks++; if (dbg_slots.ex.valid !== 1'b0) begin n_errors++; $display("FAIL fvs_bubble: got %0b expected 0", dbg_slots.ex.valid); end
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL fvs_fwd_a: got %0d expected 0", fwd_a_sel); end
    id_idle();
  endtask

  // Branch held with a valid ID instruction: flush every other edge, 4 flushes.
  task automatic test_saturation();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    ex_branch_taken = 1'b0;
    n_checks++; if (flush_count !== 2'd3) begin n_errors++; $display("FAIL sat_flush_cnt: got %0d expected 3", flush_count); end
    n_checks++; if (stall_count !== 2'd0) begin n_errors++; $display("FAIL sat_stall_cnt: got %0d expected 0", stall_count); end
    id_idle();
  endtask

  task automatic test_freeze_reset();
    do_reset();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    tick();
    // add x10 now in EX with fwd_a_sel = 1; freeze with a taken branch
    set_id(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 5'd6, 1'b1, 1'b0);
    mem_wait = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    n_checks++; if (flush_if_id !== 1'b1) begin n_errors++; $display("FAIL frz_flush_comb: got %0b expected 1", flush_if_id); end
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (fwd_a_sel !== 2'd1) begin n_errors++; $display("FAIL frz_fwd_a: got %0d expected 1", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL frz_fwd_b: got %0d expected 0", fwd_b_sel); end
    n_checks++; if (stall_count !== 2'd1) begin n_errors++; $display("FAIL frz_stall_cnt: got %0d expected 1", stall_count); end
    n_checks++; if (flush_count !== 2'd0) begin n_errors++; $display("FAIL frz_flush_cnt: got %0d expected 0", flush_count); end
    n_checks++; if (dbg_slots.ex.rd !== 5'd10) begin n_errors++; $display("FAIL frz_ex_rd: got %0d expected 10", dbg_slots.ex.rd); end
    mem_wait = 1'b0;
    ex_branch_taken = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++; if (dbg_slots !== slots_t'(0)) begin n_errors++; $display("FAIL rst_slots: got %h expected 0", dbg_slots); end
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL rst_fwd_a: got %0d expected 0", fwd_a_sel); end
    n_checks++; if (stall_count !== 2'd0) begin n_errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_count); end
    n_checks++; if (stall_if_id !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %0b expected 0", stall_if_id); end
    n_checks++; if (flush_if_id !== 1'b0) begin n_errors++; $display("FAIL rst_flush: got %0b expected 0", flush_if_id); end
    // First post-reset consumer of the old in-flight x10 reads the register file.
    set_id(1'b1, 5'd10, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
    tick();
    n_checks++; if (fwd_a_sel !== 2'd0) begin n_errors++; $display("FAIL post_rst_fwd_a: got %0d expected 0", fwd_a_sel); end
    n_checks++; if (fwd_b_sel !== 2'd0) begin n_errors++; $display("FAIL post_rst_fwd_b: got %0d expected 0", fwd_b_sel); end
    id_idle();
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_distance2();
    test_load_use();
    test_zero_reg();
    test_flush_vs_stall();
    test_saturation();
    test_freeze_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
